// File: rtl/xnor_conv_feeder_pkg.sv
// Shared definitions for the XNOR convolution feeder, PE array and popcount collector.
package xnor_conv_feeder_pkg;

    localparam int unsigned KDIM_DEFAULT = 3;

    typedef enum logic [1:0] {
        StIdle,
        StLoadW,
        StStream,
        StFinish
    } state_e;

    // Flat bit position of window element (row r, column c); column 0 is the oldest.
    function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                        input int unsigned k = KDIM_DEFAULT);
        return r * k + c;
    endfunction

endpackage

// File: rtl/xnor_conv_feeder_window.sv
// KDIM x KDIM sliding window: each shift drops column 0 and inserts a new column at KDIM-1.
module conv_window_shift
    import xnor_conv_feeder_pkg::*;
#(
    parameter int unsigned KDIM = KDIM_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_shift,
    input  logic                   i_clear,
    input  logic [KDIM-1:0]        i_col,
    output logic [KDIM*KDIM-1:0]   o_window,
    output logic [KDIM*KDIM-1:0]   o_next
);

    logic [KDIM*KDIM-1:0] r_window;

    // o_next is the window as it will look after this shift, used by the caller for emission.
    for (genvar r = 0; r < KDIM; r++) begin : g_row
        assign o_next[idx(r, 0, KDIM) +: KDIM] = {i_col[r], r_window[idx(r, 1, KDIM) +: KDIM-1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_window <= '0;
        end else if (i_clear) begin
            r_window <= '0;
        end else if (i_shift) begin
            r_window <= o_next;
        end
    end

    assign o_window = r_window;

endmodule

// File: rtl/xnor_conv_feeder.sv
// Kernel loader and sliding-window sequencer feeding a KDIM x KDIM XNOR PE array.
module xnor_conv_feeder
    import xnor_conv_feeder_pkg::*;
#(
    parameter int unsigned KDIM  = KDIM_DEFAULT,
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_cfg_valid,
    output logic                   o_cfg_ready,
    input  logic [KDIM*KDIM-1:0]   i_cfg_kernel,
    input  logic                   i_pix_valid,
    output logic                   o_pix_ready,
    input  logic [KDIM-1:0]        i_pix_data,
    output logic                   o_pe_en,
    output logic [KDIM*KDIM-1:0]   o_weight_control,
    output logic [KDIM*KDIM-1:0]   o_weight_in,
    output logic                   o_pe_start,
    output logic [KDIM*KDIM-1:0]   o_intop,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int unsigned NW     = KDIM * KDIM;
    localparam int unsigned NBANDS = IMG_H - KDIM + 1;
    localparam int unsigned CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned BW     = (NBANDS > 1) ? $clog2(NBANDS) : 1;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(KDIM - 1);
    localparam logic [BW-1:0] BAND_LAST     = BW'(NBANDS - 1);

    state_e         r_state, w_state_next;
    logic [CW-1:0]  r_col, w_col_next;
    logic [BW-1:0]  r_band, w_band_next;
    logic           w_beat, w_emit, w_clear;
    logic [NW-1:0]  w_window, w_window_next;

    logic           r_cfg_ready, r_pix_ready, r_pe_en, r_pe_start, r_busy, r_done;
    logic [NW-1:0]  r_weight_control, r_weight_in, r_intop;

    always_comb begin
        w_state_next = r_state;
        w_col_next   = r_col;
        w_band_next  = r_band;
        w_clear      = 1'b0;
        w_beat       = (r_state == StStream) && r_pix_ready && i_pix_valid;
        w_emit       = w_beat && (r_col >= COL_FIRST_WIN);
        case (r_state)
            StIdle: begin
                if (i_cfg_valid && r_cfg_ready) w_state_next = StLoadW;
            end
            StLoadW: w_state_next = StStream;
            StStream: begin
                if (w_beat) begin
                    if (r_col == COL_LAST) begin
                        w_col_next = '0;
                        w_clear    = 1'b1;
                        if (r_band == BAND_LAST) begin
                            w_band_next  = '0;
                            w_state_next = StFinish;
                        end else begin
                            w_band_next = r_band + 1'b1;
                        end
                    end else begin
                        w_col_next = r_col + 1'b1;
                    end
                end
            end
            StFinish: w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    conv_window_shift #(
        .KDIM(KDIM)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .i_shift  (w_beat),
        .i_clear  (w_clear),
        .i_col    (i_pix_data),
        .o_window (w_window),
        .o_next   (w_window_next)
    );

    // Outputs decode the next state so each one lines up with the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= StIdle;
            r_col            <= '0;
            r_band           <= '0;
            r_cfg_ready      <= 1'b0;
            r_pix_ready      <= 1'b0;
            r_pe_en          <= 1'b0;
            r_weight_control <= '0;
            r_weight_in      <= '0;
            r_pe_start       <= 1'b0;
            r_intop          <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_col            <= w_col_next;
            r_band           <= w_band_next;
            r_cfg_ready      <= (w_state_next == StIdle);
            r_pix_ready      <= (w_state_next == StStream);
            r_pe_en          <= (w_state_next == StLoadW) || (w_state_next == StStream);
            r_weight_control <= (w_state_next == StLoadW) ? '1 : '0;
            r_weight_in      <= (w_state_next == StLoadW) ? i_cfg_kernel : '0;
            r_pe_start       <= w_emit;
            r_busy           <= (w_state_next != StIdle);
            r_done           <= (w_state_next == StFinish);
            if (w_emit) r_intop <= w_window_next;
        end
    end

    assign o_cfg_ready      = r_cfg_ready;
    assign o_pix_ready      = r_pix_ready;
    assign o_pe_en          = r_pe_en;
    assign o_weight_control = r_weight_control;
    assign o_weight_in      = r_weight_in;
    assign o_pe_start       = r_pe_start;
    assign o_intop          = r_intop;
    assign o_busy           = r_busy;
    assign o_done           = r_done;

endmodule

// File: tb/tb_xnor_conv_feeder.sv
// Randomised bench for xnor_conv_feeder against a history-based behavioural model.
module tb_xnor_conv_feeder;

    localparam int K      = 3;
    localparam int W      = 8;
    localparam int H      = 8;
    localparam int NB     = H - K + 1;
    localparam int NW     = K * K;
    localparam int BEATS  = W * NB;
    localparam int STARTS = (W - K + 1) * NB;

    logic          clk, rst;
    logic          cfg_valid, cfg_ready;
    logic [NW-1:0] cfg_kernel;
    logic          pix_valid, pix_ready;
    logic [K-1:0]  pix_data;
    logic          pe_en, pe_start, busy, done;
    logic [NW-1:0] weight_control, weight_in, intop;

    xnor_conv_feeder #(
        .KDIM (K),
        .IMG_W(W),
        .IMG_H(H)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_cfg_valid     (cfg_valid),
        .o_cfg_ready     (cfg_ready),
        .i_cfg_kernel    (cfg_kernel),
        .i_pix_valid     (pix_valid),
        .o_pix_ready     (pix_ready),
        .i_pix_data      (pix_data),
        .o_pe_en         (pe_en),
        .o_weight_control(weight_control),
        .o_weight_in     (weight_in),
        .o_pe_start      (pe_start),
        .o_intop         (intop),
        .o_busy          (busy),
        .o_done          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    function automatic void chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endfunction

    function automatic void chkv(input string name, input logic [NW-1:0] act,
                                 input logic [NW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic void chki(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endfunction

    // Behavioural model: phase plus the list of accepted columns; windows are rebuilt from history.
    int            m_mode;  // 0 idle, 1 kernel load, 2 streaming, 3 finish
    int            m_beats;
    logic [K-1:0]  hist[$];
    logic [NW-1:0] m_intop_q[$];
    logic          e_cfg_ready, e_pix_ready, e_pe_en, e_pe_start, e_busy, e_done;
    logic [NW-1:0] e_wctl, e_win, e_intop;

    function automatic void model_step();
        if (rst) begin
            m_mode  = 0;
            m_beats = 0;
            e_cfg_ready = 1'b0; e_pix_ready = 1'b0; e_pe_en = 1'b0;
            e_pe_start  = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            e_wctl = '0; e_win = '0; e_intop = '0;
            return;
        end
        e_pe_start = 1'b0;
        e_win      = '0;
        case (m_mode)
            0: if (cfg_valid && e_cfg_ready) begin
                m_mode  = 1;
                e_win   = cfg_kernel;
                m_beats = 0;
                hist.delete();
            end
            1: m_mode = 2;
            2: if (pix_valid) begin
                hist.push_back(pix_data);
                m_beats++;
                if ((m_beats - 1) % W >= K - 1) begin
                    e_pe_start = 1'b1;
                    for (int c = 0; c < K; c++) begin
                        for (int r = 0; r < K; r++) begin
                            e_intop[r*K+c] = hist[m_beats-K+c][r];
                        end
                    end
                    m_intop_q.push_back(e_intop);
                end
                if (m_beats == BEATS) m_mode = 3;
            end
            default: m_mode = 0;
        endcase
        e_cfg_ready = (m_mode == 0);
        e_pix_ready = (m_mode == 2);
        e_pe_en     = (m_mode == 1) || (m_mode == 2);
        e_busy      = (m_mode != 0);
        e_done      = (m_mode == 3);
        e_wctl      = (m_mode == 1) ? '1 : '0;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle comparison against the model, plus bookkeeping of observed starts.
    bit            chk_en = 1'b0;
    int            n_starts, n_done, n_wctl;
    int            start_beat[$];
    logic [NW-1:0] start_intop[$];

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk1("cfg_ready", cfg_ready, e_cfg_ready);
                chk1("pix_ready", pix_ready, e_pix_ready);
                chk1("pe_en", pe_en, e_pe_en);
                chk1("pe_start", pe_start, e_pe_start);
                chk1("busy", busy, e_busy);
                chk1("done", done, e_done);
                chkv("weight_control", weight_control, e_wctl);
                chkv("weight_in", weight_in, e_win);
                chkv("intop", intop, e_intop);
                if (pe_start === 1'b1) begin
                    n_starts++;
                    start_beat.push_back(m_beats);
                    start_intop.push_back(intop);
                end
                if (done === 1'b1) n_done++;
                if (weight_control !== '0) n_wctl++;
            end
        end
    end

    logic [K-1:0] img[BEATS];

    task automatic clear_stats();
        n_starts = 0;
        n_done   = 0;
        n_wctl   = 0;
        start_beat.delete();
        start_intop.delete();
        m_intop_q.delete();
    endtask

    task automatic handshake(input logic [NW-1:0] kernel);
        int n = 0;
        while (!e_cfg_ready && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 20) chk1("cfg_ready_timeout", 1'b0, 1'b1);
        cfg_valid  = 1'b1;
        cfg_kernel = kernel;
        @(negedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    // style 0: continuous, 1: valid toggles, 2: random valid with stray cfg_valid
    task automatic stream(input int style, input int stop_at);
        int n = 0;
        while (n < 600) begin
            @(negedge clk); #1;
            n++;
            if (stop_at >= 0 && m_beats >= stop_at) break;
            if (m_mode == 0) break;
            case (style)
                0:       pix_valid = 1'b1;
                1:       pix_valid = n[0];
                default: pix_valid = ($urandom % 4) != 0;
            endcase
            if (style == 2) begin
                cfg_valid  = $urandom_range(0, 1) == 1;
                cfg_kernel = NW'($urandom);
            end
            pix_data = img[(m_beats < BEATS) ? m_beats : 0];
        end
        pix_valid = 1'b0;
        cfg_valid = 1'b0;
        if (n >= 600) chk1("stream_timeout", 1'b0, 1'b1);
    endtask

    logic [NW-1:0] run1_seq[$];

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_kernel = '0; pix_valid = 1'b0; pix_data = '0;
        clear_stats();
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk); #1;
        chk1("reset_cfg_ready", cfg_ready, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chkv("reset_intop", intop, '0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk1("idle_cfg_ready", cfg_ready, 1'b1);

        img[0] = 3'b001; img[1] = 3'b010; img[2] = 3'b100;
        for (int i = 3; i < BEATS; i++) img[i] = K'($urandom);

        // Run 1: kernel load then continuous stream
        handshake(9'b101010101);
        chkv("load_wctl", weight_control, 9'h1FF);
        chkv("load_win", weight_in, 9'h155);
        chk1("load_busy", busy, 1'b1);
        stream(0, -1);
        chki("run1_beats", m_beats, BEATS);
        chki("run1_starts", n_starts, STARTS);
        chki("run1_done", n_done, 1);
        chki("run1_wctl_cycles", n_wctl, 1);
        chk1("cfg_ready_after_done", cfg_ready, 1'b1);
        chki("first_start_beat", (start_beat.size() > 0) ? start_beat[0] : -1, 3);
        chkv("first_intop", (start_intop.size() > 0) ? start_intop[0] : '0, 9'b100_010_001);
        chki("band0_last_start", (start_beat.size() > 5) ? start_beat[5] : -1, 8);
        chki("band1_first_start", (start_beat.size() > 6) ? start_beat[6] : -1, 11);
        run1_seq = m_intop_q;

        // Run 2: same image under toggling backpressure
        clear_stats();
        handshake(NW'($urandom));
        stream(1, -1);
        chki("run2_starts", n_starts, STARTS);
        for (int i = 0; i < STARTS; i++) begin
            chkv("run2_intop_seq", (i < start_intop.size()) ? start_intop[i] : '0,
                 (i < run1_seq.size()) ? run1_seq[i] : '1);
        end

        // Run 3: abort mid-stream, then restart on a fresh random image
        clear_stats();
        handshake(NW'($urandom));
        stream(0, 20);
        rst = 1'b1;
        @(negedge clk); #1;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_pe_en", pe_en, 1'b0);
        chk1("abort_pix_ready", pix_ready, 1'b0);
        chkv("abort_intop", intop, '0);
        rst = 1'b0;
        for (int i = 0; i < BEATS; i++) img[i] = K'($urandom);
        clear_stats();
        handshake(NW'($urandom));
        stream(2, -1);
        chki("run3_beats", m_beats, BEATS);
        chki("run3_starts", n_starts, STARTS);
        chki("run3_first_start_beat", (start_beat.size() > 0) ? start_beat[0] : -1, 3);
        chki("run3_done", n_done, 1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
